// File: rtl/wb_stage.sv
// Write-back stage: retires ALU/CSR results directly and parks loads until
// memory data returns, then extends the data and writes the register file.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a packet; non-loads write back one cycle later
// WAIT_LOAD | a load is outstanding; waiting for the i_mem_rvalid pulse
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REGS     = 32,
  localparam int AW        = $clog2(N_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [AW-1:0]         i_rd,
  input  logic                  i_is_load,
  input  logic [2:0]            i_ld_funct3,
  input  logic [1:0]            i_ld_offset,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_rf_we,
  output logic [AW-1:0]         o_rf_waddr,
  output logic [DATA_WIDTH-1:0] o_rf_wdata,
  output logic                  o_pend_valid,
  output logic [AW-1:0]         o_pend_rd,
  output logic [31:0]           o_retired
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic       accept;
  logic       take_load;
  logic       take_alu;
  logic       load_done;
  logic [2:0] pend_funct3;
  logic [1:0] pend_offset;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  assign o_ready      = (state == IDLE);
  assign o_pend_valid = (state == WAIT_LOAD);
  assign accept       = i_valid && o_ready;
  assign take_load    = accept && i_is_load;
  assign take_alu     = accept && !i_is_load;
  // i_mem_rvalid only matters while a load is outstanding
  assign load_done    = (state == WAIT_LOAD) && i_mem_rvalid;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; i_valid is ignored while waiting, even on the return cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (take_load) state_nxt = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (i_mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the load descriptor so upstream is free to change its inputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pend_rd   <= '0;
      pend_funct3 <= '0;
      pend_offset <= '0;
    end else if (take_load) begin
      o_pend_rd   <= i_rd;
      pend_funct3 <= i_ld_funct3;
      pend_offset <= i_ld_offset;
    end
  end

  // Lane select and extension of the returned memory word
  always_comb begin
    ld_byte = '0;
    ld_half = '0;
    ld_data = '0;
    case (pend_offset)
      2'd0:    ld_byte = i_mem_rdata[7:0];
      2'd1:    ld_byte = i_mem_rdata[15:8];
      2'd2:    ld_byte = i_mem_rdata[23:16];
      default: ld_byte = i_mem_rdata[31:24];
    endcase
    // offset bit 0 is don't-care for halfwords
    ld_half = pend_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (pend_funct3)
      3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  // Register-file write port; address/data only move on a real write (rd != 0)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      o_rf_we <= 1'b0;
      if (take_alu && (i_rd != '0)) begin
        o_rf_we    <= 1'b1;
        o_rf_waddr <= i_rd;
        o_rf_wdata <= i_result;
      end else if (load_done && (o_pend_rd != '0)) begin
        o_rf_we    <= 1'b1;
        o_rf_waddr <= o_pend_rd;
        o_rf_wdata <= ld_data;
      end
    end
  end

  // Retire counter counts every completion, including suppressed rd=0 writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_retired <= '0;
    end else if (take_alu || load_done) begin
      o_retired <= o_retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a write scoreboard.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [4:0]  rd;
  logic        is_load;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic [31:0] result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;
  int exp_retired = 0;
  int ready_low = 0;

  logic [4:0]  q_addr[$];
  logic [31:0] q_data[$];

  wb_stage #(.DATA_WIDTH(32), .N_REGS(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_rd(rd), .i_is_load(is_load), .i_ld_funct3(funct3), .i_ld_offset(offset),
    .i_result(result), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_pend_valid(pend_valid), .o_pend_rd(pend_rd), .o_retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop and compare whenever the DUT writes; an unrequested write is an error
  task automatic mon();
    logic [4:0]  ea;
    logic [31:0] ed;
    if (rf_we === 1'b1) begin
      if (q_addr.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        chk("sb_waddr", {27'd0, rf_waddr}, {27'd0, ea});
        chk("sb_wdata", rf_wdata, ed);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] res);
    valid = 1'b1; is_load = 1'b0; rd = r; result = res;
    if (r != 5'd0) push(r, res);
    tick();
    valid = 1'b0;
    exp_retired++;
  endtask

  // Issue a load, idle for wait_cyc cycles, then return memory data
  task automatic load(input string tag, input logic [4:0] r, input logic [2:0] f3,
                      input logic [1:0] off, input logic [31:0] rdata,
                      input logic [31:0] exp, input int wait_cyc);
    valid = 1'b1; is_load = 1'b1; rd = r; funct3 = f3; offset = off;
    tick();
    valid = 1'b0; funct3 = ~f3; offset = ~off; rd = 5'd31;
    chk({tag, "_pend_valid"}, {31'd0, pend_valid}, 32'd1);
    chk({tag, "_pend_rd"}, {27'd0, pend_rd}, {27'd0, r});
    chk({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
    for (int i = 0; i < wait_cyc; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    if (r != 5'd0) push(r, exp);
    tick();
    mem_rvalid = 1'b0;
    exp_retired++;
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, (r != 5'd0)});
    chk({tag, "_pend_clear"}, {31'd0, pend_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; rd = '0; is_load = 1'b0; funct3 = '0; offset = '0;
    result = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pend", {31'd0, pend_valid}, 32'd0);
    chk("rst_pend_rd", {27'd0, pend_rd}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // First packet right after reset release
    alu(5'd5, 32'h1234_5678);
    chk("alu_we", {31'd0, rf_we}, 32'd1);
    chk("alu_retired", retired, exp_retired);
    tick();
    chk("alu_we_one_cycle", {31'd0, rf_we}, 32'd0);
    chk("alu_hold_wdata", rf_wdata, 32'h1234_5678);

    load("lb", 5'd7, 3'b000, 2'd2, 32'hAA80_55CC, 32'hFFFF_FF80, 2);
    load("lhu", 5'd8, 3'b101, 2'd3, 32'h8001_7FFF, 32'h0000_8001, 0);
    load("lh", 5'd9, 3'b001, 2'd1, 32'h1234_8765, 32'hFFFF_8765, 1);
    load("lbu", 5'd10, 3'b100, 2'd1, 32'h0000_F000, 32'h0000_00F0, 0);
    load("lw", 5'd11, 3'b010, 2'd3, 32'hCAFE_BABE, 32'hCAFE_BABE, 0);
    load("f3_other", 5'd12, 3'b011, 2'd1, 32'h8765_4321, 32'h8765_4321, 0);
    chk("load_retired", retired, exp_retired);

    // rvalid in IDLE does nothing
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_we", {31'd0, rf_we}, 32'd0);
    chk("idle_rvalid_retired", retired, exp_retired);

    // rd=0: no write, address/data hold, counter still moves
    alu(5'd0, 32'hDEAD_BEEF);
    chk("rd0_we", {31'd0, rf_we}, 32'd0);
    chk("rd0_retired", retired, exp_retired);
    chk("rd0_hold_waddr", {27'd0, rf_waddr}, 32'd12);
    chk("rd0_hold_wdata", rf_wdata, 32'h8765_4321);
    load("ld_rd0", 5'd0, 3'b010, 2'd0, 32'h1111_1111, 32'h0, 2);
    chk("ld_rd0_retired", retired, exp_retired);

    // Stall: valid held high through three non-loads, a load and a follower
    valid = 1'b1; is_load = 1'b0;
    rd = 5'd1; result = 32'hA000_0001; push(5'd1, 32'hA000_0001);
    tick(); exp_retired++;
    chk("stall_w1", {31'd0, rf_we}, 32'd1);
    rd = 5'd2; result = 32'hA000_0002; push(5'd2, 32'hA000_0002);
    tick(); exp_retired++;
    chk("stall_w2", {31'd0, rf_we}, 32'd1);
    rd = 5'd3; result = 32'hA000_0003; push(5'd3, 32'hA000_0003);
    tick(); exp_retired++;
    chk("stall_w3", {31'd0, rf_we}, 32'd1);
    is_load = 1'b1; rd = 5'd4; funct3 = 3'b010; offset = 2'd0;
    tick();
    if (ready === 1'b0) ready_low++;
    is_load = 1'b0; rd = 5'd6; result = 32'hB000_0006;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready === 1'b0) ready_low++;
    end
    chk("stall_ready_low_cycles", ready_low, 32'd5);
    mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444; push(5'd4, 32'h4444_4444);
    tick(); exp_retired++;
    mem_rvalid = 1'b0;
    chk("stall_load_we", {31'd0, rf_we}, 32'd1);
    chk("stall_load_ready", {31'd0, ready}, 32'd1);
    push(5'd6, 32'hB000_0006);
    tick(); exp_retired++;
    valid = 1'b0;
    chk("stall_follower_we", {31'd0, rf_we}, 32'd1);
    chk("stall_retired", retired, exp_retired);
    tick();

    // Reset during WAIT_LOAD discards the load
    valid = 1'b1; is_load = 1'b1; rd = 5'd9; funct3 = 3'b010;
    tick();
    valid = 1'b0;
    chk("rst_mid_pend", {31'd0, pend_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async_pend", {31'd0, pend_valid}, 32'd0);
    chk("rst_mid_async_retired", retired, 32'd0);
    chk("rst_mid_async_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_mid_no_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mid_retired", retired, 32'd0);
    chk("rst_mid_pend_after", {31'd0, pend_valid}, 32'd0);

    chk("sb_drained", q_addr.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
